// File: rtl/spm_pkg.sv
// Shared definitions for the streaming serial/parallel multiplier.
package spm_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } spm_state_e;

    // Cycles from the accept edge to the first cycle out_valid is high.
    function automatic int lat(input int bits);
        return 2 * bits + 2;
    endfunction

    // Counter width needed to count up to lat(bits).
    function automatic int cnt_w(input int bits);
        return $clog2(2 * bits + 3);
    endfunction

endpackage : spm_pkg

// File: rtl/spm_stream_cell.sv
// One carry-save serial adder bit: adds x&a to the partial sum arriving from
// the next-higher cell, keeps its own carry, and passes its sum bit down.
module spm_stream_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic x,
    input  logic a,
    input  logic y_in,
    output logic y_out
);

    logic g;
    logic sum_d, sum_q;
    logic carry_d, carry_q;

    // Full add of the partial product, incoming sum and stored carry.
    always_comb begin
        g       = x & a;
        sum_d   = g ^ y_in ^ carry_q;
        carry_d = (g & y_in) | (g & carry_q) | (y_in & carry_q);
        if (clr) begin
            sum_d   = 1'b0;
            carry_d = 1'b0;
        end
    end

    // Sum and carry registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign y_out = sum_q;

endmodule : spm_stream_cell

// File: rtl/spm_stream.sv
// Streaming serial/parallel multiplier: accepts a and x in parallel, shifts
// |x| LSB-first through a chain of serial adder cells, collects the serial
// product and applies the sign on completion. Fixed latency, no overlap.
module spm_stream
    import spm_pkg::*;
#(
    parameter  int bits  = 32,
    localparam int CNT_W = cnt_w(bits)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              signed_mode,
    input  logic [bits-1:0]   a,
    input  logic [bits-1:0]   x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*bits-1:0] p,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(lat(bits) - 1);

    spm_state_e        state_d, state_q;
    logic [bits-1:0]   a_d, a_q;
    logic [bits-1:0]   x_sr_d, x_sr_q;
    logic              neg_d, neg_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [2*bits-1:0] prod_d, prod_q;
    logic [2*bits-1:0] p_d, p_q;
    logic [bits-1:0]   a_mag, x_mag;
    logic              cell_clr;
    logic              cell_x;
    logic [bits:0]     y;

    // Operand magnitudes; -2^(bits-1) negates to itself, which is the
    // correct unsigned magnitude 2^(bits-1).
    always_comb begin
        a_mag = (signed_mode && a[bits-1]) ? -a : a;
        x_mag = (signed_mode && x[bits-1]) ? -x : x;
    end

    // Next-state logic for the controller, operand and product registers.
    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        x_sr_d   = x_sr_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        p_d      = p_q;
        cell_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a_mag;
                    x_sr_d   = x_mag;
                    neg_d    = signed_mode & (a[bits-1] ^ x[bits-1]);
                    cnt_d    = '0;
                    prod_d   = '0;
                    cell_clr = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // x drains LSB first and zero-fills once its bits are spent.
                x_sr_d = x_sr_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                // Serial product bits arrive LSB first; shift in at the top.
                prod_d = {y[0], prod_q[2*bits-1:1]};
                if (cnt_q == LAST_CNT) begin
                    p_d     = neg_q ? -prod_q : prod_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller, operand and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            x_sr_q  <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            x_sr_q  <= x_sr_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            p_q     <= p_d;
        end
    end

    // Only feed multiplicand bits while running so idle cells stay quiet.
    assign cell_x  = (state_q == RUN) & x_sr_q[0];
    assign y[bits] = 1'b0;

    // Cell chain: cell i holds a[i]; sums ripple from the top cell down to
    // cell 0, whose output is the serial product.
    for (genvar i = 0; i < bits; i++) begin : g_cell
        spm_stream_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .clr   (cell_clr),
            .x     (cell_x),
            .a     (a_q[i]),
            .y_in  (y[i+1]),
            .y_out (y[i])
        );
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign p         = p_q;

endmodule : spm_stream
